bitwise_op_sequencer: RTL and testbench
=======================================

Name: bitwise_op_sequencer

Overview:
- Multi-cycle bitwise/reduction/logical operator engine for ascending-range operand vectors (`[0:WIDTH-1]`, index 0 is the MSB).
- Accepts one operation per transaction over a valid/ready handshake.
- Evaluates CHUNK bits per cycle, walking from index 0 upward, and returns the result through a valid/ready output handshake.
- Acts as the scheduler/controller in front of the shared chunk-wide bitwise datapath.

Parameters:
- WIDTH, 16, operand/result width. Range is `[0:WIDTH-1]`. Must be a multiple of CHUNK.
- CHUNK, 4, bits evaluated per RUN cycle. N = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- op  input  4  opcode (see Behaviour)
- a  input  [0:WIDTH-1]  operand A
- b  input  [0:WIDTH-1]  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer ready
- result  output  [0:WIDTH-1]  bitwise result
- flag  output  1  reduction/logical result
- busy  output  1  high in RUN or DONE

Behaviour:
- Opcodes, bitwise ops (result written, flag=0):
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR
  - 6 NOT a, 7 PASS a
- Opcodes, flag ops (result=0):
  - 8 &a, 9 |a, 10 ~&a, 11 ~|a, 12 ^a, 13 ~^a
  - 14 (a!=0)&&(b!=0), 15 (a!=0)||(b!=0)
- All 16 codes are legal.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On accept, register op/a/b, clear result/flag/accumulators, clear chunk counter k=0, go to RUN.
  - RUN: in_ready=0. Each cycle processes indices `[k*CHUNK : k*CHUNK+CHUNK-1]`:
    - Bitwise ops write those result bits.
    - Flag ops update accumulators: and_acc (init 1), or_a (init 0), or_b (init 0), xor_acc (init 0).
    - Increment k. After the chunk with k=N-1, go to DONE.
  - DONE: compute flag from the accumulators, applying complement for ops 10/11/13. Hold out_valid=1 with result/flag stable until out_ready=1, then go to IDLE.
- Latency:
  - Accept at edge T; the N chunks complete at edges T+1..T+N.
  - out_valid=1 after edge T+N+1, once the flag is finalised on entry to DONE.
  - flag and result are valid together; minimum request-to-response latency is N+1 cycles.
- Operands are captured at accept. Changes to a/b/op during RUN/DONE have no effect.
- Unprocessed result bits read 0 during RUN. result/flag are not qualified until out_valid.
- No overlap:
  - The output handshake in DONE returns to IDLE. in_ready rises the following cycle, giving a one-cycle bubble.
  - An in_valid held high during RUN/DONE is neither accepted nor lost; it is taken in IDLE.
- out_ready while out_valid=0 is ignored.
- Reset (async assert, any state):
  - State goes to IDLE; in_ready=1 after deassertion.
  - out_valid=0, busy=0, result=0, flag=0, k=0.
  - Any in-flight operation is discarded; no partial output.
- busy=1 exactly when state is RUN or DONE.

Test Plan:
1. Reset: pulse rst_n low asynchronously between edges -> outputs clear immediately: out_valid=0, busy=0, result=16'h0000, flag=0. in_ready=1 after release.
2. op=0, a=16'hF0F0, b=16'hFF00 -> result=16'hF000, flag=0, out_valid after exactly 5 edges. Repeat with op=4 -> result=16'h0FF0, and op=6 -> result=16'h0F0F.
3. op=12, a=16'h0007 -> flag=1. op=13 same a -> flag=0. op=8, a=16'hFFFF -> flag=1. op=11, a=16'h0000 -> flag=1. result=0 throughout.
4. op=14, a=16'h0001, b=16'h0000 -> flag=0. op=15 same operands -> flag=1. op=14, a=16'h8000, b=16'h0001 -> flag=1.
5. Backpressure: out_ready low for 5 cycles after out_valid -> result/flag stable, out_valid held. Change a mid-RUN -> no effect. in_valid held high -> accepted only one cycle after the output handshake.
6. Assert rst_n low during RUN at k=2 -> all outputs 0, no out_valid. After release, op=1, a=16'h00FF, b=16'h0F00 -> result=16'h0FFF.

Source files
------------

// File: rtl/bitwise_op_sequencer.sv
// bitwise_op_sequencer: multi-cycle bitwise / reduction / logical operator engine.
// A request is taken over a valid/ready handshake. The engine then walks the
// ascending-range operands CHUNK bits per cycle, starting at index 0 (the MSB).
// The result and flag are returned over a second valid/ready handshake.
module bitwise_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [3:0]       i_op,
  input  logic [0:WIDTH-1] i_a,
  input  logic [0:WIDTH-1] i_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [0:WIDTH-1] o_result,
  output logic             o_flag,
  output logic             o_busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [3:0]       r_op;
  logic [0:WIDTH-1] r_a;
  logic [0:WIDTH-1] r_b;
  logic [0:WIDTH-1] r_result;
  logic             r_flag;
  logic             r_out_valid;
  logic [KW-1:0]    r_k;
  logic             r_and_acc;
  logic             r_or_a;
  logic             r_or_b;
  logic             r_xor_acc;

  logic [BW-1:0]    w_base;
  logic [0:CHUNK-1] w_chunk_a;
  logic [0:CHUNK-1] w_chunk_b;
  logic [0:CHUNK-1] w_chunk_res;
  logic             w_flag;
  logic             w_last_chunk;

  // First index of the chunk handled in the current RUN cycle.
  assign w_base       = BW'(r_k) * BW'(CHUNK);
  assign w_chunk_a    = r_a[w_base +: CHUNK];
  assign w_chunk_b    = r_b[w_base +: CHUNK];
  assign w_last_chunk = (r_k == KW'(N - 1));

  // Chunk-wide bitwise datapath; only meaningful for opcodes 0..7.
  always_comb begin
    w_chunk_res = '0;
    case (r_op[2:0])
      3'd0:    w_chunk_res = w_chunk_a & w_chunk_b;
      3'd1:    w_chunk_res = w_chunk_a | w_chunk_b;
      3'd2:    w_chunk_res = ~(w_chunk_a & w_chunk_b);
      3'd3:    w_chunk_res = ~(w_chunk_a | w_chunk_b);
      3'd4:    w_chunk_res = w_chunk_a ^ w_chunk_b;
      3'd5:    w_chunk_res = ~(w_chunk_a ^ w_chunk_b);
      3'd6:    w_chunk_res = ~w_chunk_a;
      default: w_chunk_res = w_chunk_a;
    endcase
  end

  // Final flag from the accumulators once every chunk has been folded in.
  always_comb begin
    w_flag = 1'b0;
    case (r_op)
      4'd8:    w_flag = r_and_acc;
      4'd9:    w_flag = r_or_a;
      4'd10:   w_flag = ~r_and_acc;
      4'd11:   w_flag = ~r_or_a;
      4'd12:   w_flag = r_xor_acc;
      4'd13:   w_flag = ~r_xor_acc;
      4'd14:   w_flag = r_or_a & r_or_b;
      4'd15:   w_flag = r_or_a | r_or_b;
      default: w_flag = 1'b0;
    endcase
  end

  // Sequencer: capture in IDLE, walk chunks in RUN, present and hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_flag      <= 1'b0;
      r_out_valid <= 1'b0;
      r_k         <= '0;
      r_and_acc   <= 1'b1;
      r_or_a      <= 1'b0;
      r_or_b      <= 1'b0;
      r_xor_acc   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_op      <= i_op;
            r_a       <= i_a;
            r_b       <= i_b;
            r_result  <= '0;
            r_flag    <= 1'b0;
            r_k       <= '0;
            r_and_acc <= 1'b1;
            r_or_a    <= 1'b0;
            r_or_b    <= 1'b0;
            r_xor_acc <= 1'b0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (!r_op[3]) begin
            r_result[w_base +: CHUNK] <= w_chunk_res;
          end
          r_and_acc <= r_and_acc & (&w_chunk_a);
          r_or_a    <= r_or_a | (|w_chunk_a);
          r_or_b    <= r_or_b | (|w_chunk_b);
          r_xor_acc <= r_xor_acc ^ (^w_chunk_a);
          r_k       <= r_k + KW'(1);
          if (w_last_chunk) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_flag      <= w_flag;
            r_out_valid <= 1'b1;
          end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_flag      = r_flag;

endmodule

// File: tb/tb_bitwise_op_sequencer.sv
// tb_bitwise_op_sequencer: directed and randomized transactions checked
// against a whole-vector reference model of the operator set.
module tb_bitwise_op_sequencer;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic             inValid;
  logic             inReady;
  logic [3:0]       op;
  logic [0:WIDTH-1] a;
  logic [0:WIDTH-1] b;
  logic             outValid;
  logic             outReady;
  logic [0:WIDTH-1] result;
  logic             flag;
  logic             busy;

  int assertCount = 0;
  int failCount   = 0;

  bitwise_op_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_op        (op),
    .i_a         (a),
    .i_b         (b),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_result    (result),
    .o_flag      (flag),
    .o_busy      (busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a stuck handshake can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Whole-vector reference: returns {flag, result}.
  function automatic logic [WIDTH:0] refModel(input logic [3:0] mop,
                                              input logic [0:WIDTH-1] ma,
                                              input logic [0:WIDTH-1] mb);
    logic [0:WIDTH-1] r;
    logic             f;
    r = '0;
    f = 1'b0;
    case (mop)
      4'd0:  r = ma & mb;
      4'd1:  r = ma | mb;
      4'd2:  r = ~(ma & mb);
      4'd3:  r = ~(ma | mb);
      4'd4:  r = ma ^ mb;
      4'd5:  r = ~(ma ^ mb);
      4'd6:  r = ~ma;
      4'd7:  r = ma;
      4'd8:  f = &ma;
      4'd9:  f = |ma;
      4'd10: f = ~&ma;
      4'd11: f = ~|ma;
      4'd12: f = ^ma;
      4'd13: f = ~^ma;
      4'd14: f = (ma != 0) && (mb != 0);
      default: f = (ma != 0) || (mb != 0);
    endcase
    return {f, r};
  endfunction

  // Called at the negedge following the accept edge; waits for out_valid,
  // checks latency, holds the result under backpressure, then handshakes.
  task automatic waitResult(input logic [0:WIDTH-1] expRes, input logic expFlag,
                            input int stall);
    int edges;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!outValid && edges < 40);
    checkOutput("latency", edges, N + 1);
    checkOutput("result", result, expRes);
    checkOutput("flag", flag, expFlag);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("stallValid", outValid, 1);
      checkOutput("stallResult", result, expRes);
      checkOutput("stallFlag", flag, expFlag);
    end
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady = 1'b0;
    checkOutput("postHandshakeValid", outValid, 0);
    checkOutput("postHandshakeReady", inReady, 1);
  endtask

  // One full transaction. With holdValid the request stays asserted through
  // RUN/DONE and must be taken once more, only after the output handshake.
  task automatic applyStimulus(input logic [3:0] sop, input logic [0:WIDTH-1] sa,
                               input logic [0:WIDTH-1] sb, input int stall,
                               input bit holdValid);
    logic [WIDTH:0] exp;
    exp = refModel(sop, sa, sb);
    @(negedge clk);
    checkOutput("idleReady", inReady, 1);
    inValid = 1'b1;
    op = sop;
    a  = sa;
    b  = sb;
    @(posedge clk);
    @(negedge clk);
    if (!holdValid) begin
      inValid = 1'b0;
      op = 4'($urandom);
      a  = WIDTH'($urandom);
      b  = WIDTH'($urandom);
    end
    checkOutput("runBusy", busy, 1);
    checkOutput("runReady", inReady, 0);
    waitResult(exp[WIDTH-1:0], exp[WIDTH], stall);
    if (holdValid) begin
      checkOutput("bubbleBusy", busy, 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("reacceptBusy", busy, 1);
      inValid = 1'b0;
      waitResult(exp[WIDTH-1:0], exp[WIDTH], 0);
    end
  endtask

  initial begin
    logic [3:0]       rop;
    logic [0:WIDTH-1] ra;
    logic [0:WIDTH-1] rb;

    rst_n    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    op = '0;
    a  = '0;
    b  = '0;
    #23;
    checkOutput("resetValid", outValid, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetResult", result, 0);
    checkOutput("resetFlag", flag, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("resetReady", inReady, 1);

    $display("[TB] directed bitwise ops");
    applyStimulus(4'd0, 16'hF0F0, 16'hFF00, 0, 0);
    applyStimulus(4'd4, 16'hF0F0, 16'hFF00, 0, 0);
    applyStimulus(4'd6, 16'hF0F0, 16'hFF00, 0, 0);

    $display("[TB] directed reduction and logical ops");
    applyStimulus(4'd12, 16'h0007, 16'h0000, 0, 0);
    applyStimulus(4'd13, 16'h0007, 16'h0000, 0, 0);
    applyStimulus(4'd8,  16'hFFFF, 16'h0000, 0, 0);
    applyStimulus(4'd11, 16'h0000, 16'h0000, 0, 0);
    applyStimulus(4'd14, 16'h0001, 16'h0000, 0, 0);
    applyStimulus(4'd15, 16'h0001, 16'h0000, 0, 0);
    applyStimulus(4'd14, 16'h8000, 16'h0001, 0, 0);

    $display("[TB] backpressure and held request");
    applyStimulus(4'd5, 16'h1234, 16'hABCD, 5, 0);
    applyStimulus(4'd9, 16'h0100, 16'h0000, 5, 1);

    $display("[TB] reset during RUN");
    @(negedge clk);
    inValid = 1'b1;
    op = 4'd1;
    a  = 16'hFFFF;
    b  = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midResetValid", outValid, 0);
    checkOutput("midResetBusy", busy, 0);
    checkOutput("midResetResult", result, 0);
    checkOutput("midResetFlag", flag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midResetReady", inReady, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("noPartialOutput", outValid, 0);
    end
    applyStimulus(4'd1, 16'h00FF, 16'h0F00, 0, 0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 40; t++) begin
      rop = 4'($urandom);
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) ra = '0;
      if ($urandom_range(0, 3) == 0) rb = '0;
      if ($urandom_range(0, 5) == 0) ra = '1;
      applyStimulus(rop, ra, rb, $urandom_range(0, 2), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
